// File: rtl/adc_motor_pwm.sv
// adc_motor_pwm: ADC sample vs threshold -> ramped PWM forward drive with STOP/RUN/BRAKE FSM.
// Optional start hysteresis enabled by defining MOTOR_HYST_EN.
module adc_motor_pwm #(
    parameter int PRESC_DIV     = 100,
    parameter int RAMP_STEP     = 4,
    parameter int HYST          = 8,
    parameter int BRAKE_PERIODS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sample,
    input  logic       sample_vld,
    input  logic [7:0] threshold,
    output logic       motor_en,
    output logic [1:0] motor,
    output logic [7:0] duty,
    output logic       running
);

    localparam int PW = (PRESC_DIV > 2) ? $clog2(PRESC_DIV) : 1;
    localparam int BW = (BRAKE_PERIODS > 1) ? $clog2(BRAKE_PERIODS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC_DIV - 1);
    localparam logic [BW-1:0] BRK_LAST  = BW'(BRAKE_PERIODS - 1);
    localparam logic [7:0]    STEP      = 8'(RAMP_STEP);
    localparam logic [8:0]    HYST9     = 9'(HYST);
`ifdef MOTOR_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif

    typedef enum logic [1:0] {S_STOP, S_RUN, S_BRAKE} state_e;

    state_e          state_q, state_d;
    logic [BW-1:0]   brk_q, brk_d;
    logic [7:0]      smp_q, smp_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      phase_q, phase_d;
    logic [7:0]      duty_q, duty_d;
    logic [1:0]      motor_q, motor_d;
    logic            en_q, run_q, run_d;

    logic [7:0]      tgt, ramp;
    logic [8:0]      hsum;
    logic            tick, bnd, pwm_hi, start;

    // Sample latch, target, PWM timebase, ramp step and start condition
    always_comb begin
        smp_d   = sample_vld ? sample : smp_q;
        tgt     = (smp_q > threshold) ? smp_q - threshold : 8'd0;
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + PW'(1);
        phase_d = tick ? phase_q + 8'd1 : phase_q;
        bnd     = tick && (phase_q == 8'hFF);
        pwm_hi  = (phase_q < duty_q);
        if (duty_q < tgt) begin
            ramp = ((tgt - duty_q) > STEP) ? duty_q + STEP : tgt;
        end else begin
            ramp = ((duty_q - tgt) > STEP) ? duty_q - STEP : tgt;
        end
        hsum  = {1'b0, threshold} + HYST9;
        if (HYST_ON) begin
            start = hsum[8] ? (smp_q == 8'hFF) : (smp_q >= hsum[7:0]);
        end else begin
            start = (tgt != 8'd0);
        end
    end

    // FSM state register and brake period counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_STOP;
            brk_q   <= '0;
        end else begin
            state_q <= state_d;
            brk_q   <= brk_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        brk_d   = brk_q;
        unique case (state_q)
            S_STOP: begin
                brk_d = '0;
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (bnd && ramp == 8'd0 && tgt == 8'd0) state_d = S_BRAKE;
            end
            S_BRAKE: begin
                if (bnd) begin
                    if (brk_q == BRK_LAST) begin
                        brk_d   = '0;
                        state_d = S_STOP;
                    end else begin
                        brk_d = brk_q + BW'(1);
                    end
                end
            end
            default: begin
                brk_d   = '0;
                state_d = S_STOP;
            end
        endcase
    end

    // FSM outputs: bridge command, applied duty and run flag for the next cycle
    always_comb begin
        motor_d = 2'b00;
        duty_d  = 8'd0;
        run_d   = (state_d == S_RUN);
        unique case (state_d)
            S_RUN:   motor_d = pwm_hi ? 2'b10 : 2'b00;
            S_BRAKE: motor_d = 2'b11;
            default: motor_d = 2'b00;
        endcase
        if (state_q == S_RUN && state_d == S_RUN) begin
            duty_d = bnd ? ramp : duty_q;
        end
    end

    // Datapath and registered output flops
    always_ff @(posedge clk) begin
        if (!reset) begin
            smp_q   <= 8'd0;
            presc_q <= '0;
            phase_q <= 8'd0;
            duty_q  <= 8'd0;
            motor_q <= 2'b00;
            en_q    <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            smp_q   <= smp_d;
            presc_q <= presc_d;
            phase_q <= phase_d;
            duty_q  <= duty_d;
            motor_q <= motor_d;
            en_q    <= 1'b1;
            run_q   <= run_d;
        end
    end

    assign motor_en = en_q;
    assign motor    = motor_q;
    assign duty     = duty_q;
    assign running  = run_q;

endmodule

// File: tb/tb_adc_motor_pwm.sv
// tb_adc_motor_pwm: scoreboard bench for adc_motor_pwm.
// Reference model predicts every cycle's outputs; monitor compares on negedge.
module tb_adc_motor_pwm;

    localparam int P   = 2;
    localparam int RS  = 4;
    localparam int HY  = 8;
    localparam int BP  = 2;
    localparam int PER = 256 * P;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] sample = 8'd0;
    logic       sample_vld = 1'b0;
    logic [7:0] threshold = 8'd0;
    logic       motor_en;
    logic [1:0] motor;
    logic [7:0] duty;
    logic       running;

    always #5 clk = ~clk;

    adc_motor_pwm #(
        .PRESC_DIV(P),
        .RAMP_STEP(RS),
        .HYST(HY),
        .BRAKE_PERIODS(BP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sample(sample),
        .sample_vld(sample_vld),
        .threshold(threshold),
        .motor_en(motor_en),
        .motor(motor),
        .duty(duty),
        .running(running)
    );

    typedef struct {
        logic       en;
        logic [1:0] mot;
        logic [7:0] dty;
        logic       run;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // model: 0=STOP 1=RUN 2=BRAKE; time base is a cycle count since reset
    int m_smp = 0, m_duty = 0, m_state = 0, m_brk = 0, m_cyc = 0, m_mot = 0;
    bit m_en = 0;

    always @(posedge clk) begin : model
        exp_t e;
        int tgt, ph, nd, ns, lim;
        bit bnd, pwm, start;
        if (!reset) begin
            m_smp = 0; m_duty = 0; m_state = 0; m_brk = 0;
            m_cyc = 0; m_mot = 0; m_en = 0;
        end else begin
            tgt = (m_smp > threshold) ? m_smp - threshold : 0;
            lim = threshold + HY;
            if (lim > 255) lim = 255;
`ifdef MOTOR_HYST_EN
            start = (m_smp >= lim);
`else
            start = (tgt > 0);
`endif
            ph  = (m_cyc / P) % 256;
            bnd = (m_cyc == PER - 1);
            pwm = (ph < m_duty);
            ns = m_state;
            nd = m_duty;
            if (m_state == 0) begin
                nd = 0;
                if (start) ns = 1;
            end else if (m_state == 1) begin
                if (bnd) begin
                    if (tgt > m_duty)
                        nd = (tgt - m_duty > RS) ? m_duty + RS : tgt;
                    else
                        nd = (m_duty - tgt > RS) ? m_duty - RS : tgt;
                    if (nd == 0 && tgt == 0) ns = 2;
                end
            end else begin
                nd = 0;
                if (bnd) begin
                    m_brk++;
                    if (m_brk == BP) begin
                        m_brk = 0;
                        ns = 0;
                    end
                end
            end
            if (ns != 1) nd = 0;
            m_mot = (ns == 2) ? 3 : ((ns == 1 && pwm) ? 2 : 0);
            m_state = ns;
            m_duty  = nd;
            m_cyc   = (m_cyc + 1) % PER;
            if (sample_vld) m_smp = sample;
            m_en = 1;
        end
        e.en  = m_en;
        e.mot = 2'(m_mot);
        e.dty = 8'(m_duty);
        e.run = (m_state == 1);
        q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (motor_en !== e.en || motor !== e.mot ||
                duty !== e.dty || running !== e.run) begin
                failures++;
                if (failures <= 10)
                    $display("FAIL scoreboard t=%0t act en=%b mot=%b duty=%0d run=%b exp en=%b mot=%b duty=%0d run=%b",
                             $time, motor_en, motor, duty, running,
                             e.en, e.mot, e.dty, e.run);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] s);
        sample = s;
        sample_vld = 1'b1;
        @(negedge clk);
        sample_vld = 1'b0;
    endtask

    initial begin : stim
        int cnt;
        bit seen;
        cyc(3);
        chk("rst_en", motor_en, 0);
        chk("rst_duty", duty, 0);
        chk("rst_motor", motor, 0);
        reset = 1'b1;
        cyc(1);
        chk("en_after_release", motor_en, 1);

        // ramp to 40 then reset mid-run
        threshold = 8'd0;
        pulse(8'd40);
        cyc(11 * PER);
        chk("duty40", duty, 40);
        chk("run40", running, 1);
        reset = 1'b0;
        cyc(3);
        chk("midrun_rst_duty", duty, 0);
        chk("midrun_rst_run", running, 0);
        chk("midrun_rst_motor", motor, 0);
        chk("midrun_rst_en", motor_en, 0);
        reset = 1'b1;
        cyc(1);
        chk("midrun_en_release", motor_en, 1);
        cyc(10);
        chk("stop_after_rst", running, 0);

        // ramp up to 16 and count forward-drive cycles over one period
        threshold = 8'h50;
        pulse(8'h60);
        cyc(6 * PER);
        chk("duty16", duty, 16);
        cnt = 0;
        for (int i = 0; i < PER; i++) begin
            @(negedge clk);
            if (motor == 2'b10) cnt++;
        end
        chk("fwd_cycles", cnt, 16 * P);

        // ramp down, brake, stop
        pulse(8'h40);
        seen = 0;
        for (int i = 0; i < 6 * PER && !seen; i++) begin
            @(negedge clk);
            if (motor == 2'b11) seen = 1;
        end
        chk("brake_seen", seen, 1);
        seen = 0;
        for (int i = 0; i < 3 * PER && !seen; i++) begin
            @(negedge clk);
            if (motor == 2'b00 && !running) seen = 1;
        end
        chk("stop_after_brake", seen, 1);

        // start hysteresis
        pulse(8'h55);
        cyc(5);
`ifdef MOTOR_HYST_EN
        chk("hyst_55", running, 0);
`else
        chk("hyst_55", running, 1);
`endif
        pulse(8'h58);
        cyc(5);
        chk("hyst_58", running, 1);
        pulse(8'h00);
        cyc(5 * PER);
        chk("hyst_stop", running, 0);

        // equal saturated inputs, then full-scale ramp
        threshold = 8'hFF;
        pulse(8'hFF);
        cyc(20);
        chk("ff_ff_stop", running, 0);
        threshold = 8'h00;
        cyc(66 * PER);
        chk("duty255", duty, 255);
        cyc(PER);
        chk("duty255_hold", duty, 255);

        // new sample on the boundary cycle
        seen = 0;
        for (int i = 0; i < PER + 1 && !seen; i++) begin
            if (m_cyc == PER - 1) seen = 1;
            else @(negedge clk);
        end
        chk("bnd_found", seen, 1);
        pulse(8'h80);
        chk("bnd_old_tgt", duty, 255);
        cyc(PER);
        chk("bnd_new_tgt", duty, 251);

        // randomized traffic, scoreboard only
        for (int k = 0; k < 40; k++) begin
            int a;
            a = $urandom_range(0, 9);
            if (a < 5) pulse(8'($urandom_range(0, 255)));
            else if (a < 8) threshold = 8'($urandom_range(0, 160));
            else if (a == 8) begin
                reset = 1'b0;
                cyc(1);
                reset = 1'b1;
            end else begin
                threshold = 8'($urandom_range(0, 20));
                pulse(8'($urandom_range(0, 40)));
            end
            cyc($urandom_range(1, PER / 2));
        end
        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
